// File: rtl/csr_trap_pkg.sv
// Shared types and constants for the CSR trap/return sequencer.
package csr_trap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EPC,
        ST_CAUSE,
        ST_TVAL,
        ST_STATUS,
        ST_MSTAT_RET,
        ST_REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_EXC,
        EV_MRET,
        EV_IRQ
    } event_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam logic [3:0] IRQ_CODE_EXT   = 4'd11;
    localparam logic [3:0] IRQ_CODE_TIMER = 4'd7;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

endpackage

// File: rtl/csr_trap_ctrl_if.sv
// Commit-stage CSR write request and the register-file write port it shares with the trap sequencer.
interface csr_trap_ctrl_if #(parameter int XLEN = 32);

    logic            commit_csr_we;
    logic [11:0]     commit_csr_addr;
    logic [XLEN-1:0] commit_csr_wdata;
    logic            commit_csr_stall;
    logic            csr_we;
    logic [11:0]     csr_waddr;
    logic [XLEN-1:0] csr_wdata;

    modport master (
        output commit_csr_we, commit_csr_addr, commit_csr_wdata,
        input  commit_csr_stall, csr_we, csr_waddr, csr_wdata
    );

    modport slave (
        input  commit_csr_we, commit_csr_addr, commit_csr_wdata,
        output commit_csr_stall, csr_we, csr_waddr, csr_wdata
    );

endinterface

// File: rtl/csr_trap_prio.sv
// Picks the event to accept at a commit boundary and encodes its mcause value.
module csr_trap_prio
    import csr_trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic            mret_valid,
    input  logic            commit_boundary,
    input  logic            mstatus_mie,
    input  logic            ext_irq,
    input  logic            timer_irq,
    input  logic            mie_meie,
    input  logic            mie_mtie,
    output event_t          ev,
    output logic [XLEN-1:0] cause
);

    logic irq_ext;
    logic irq_timer;

    // Exceptions outrank mret, which outranks interrupts; external beats timer.
    always_comb begin
        irq_ext   = commit_boundary & mstatus_mie & ext_irq & mie_meie;
        irq_timer = commit_boundary & mstatus_mie & timer_irq & mie_mtie;
        ev        = EV_NONE;
        cause     = '0;
        if (exc_valid) begin
            ev         = EV_EXC;
            cause[3:0] = exc_cause;
        end else if (mret_valid) begin
            ev = EV_MRET;
        end else if (irq_ext) begin
            ev              = EV_IRQ;
            cause[XLEN-1]   = 1'b1;
            cause[3:0]      = IRQ_CODE_EXT;
        end else if (irq_timer) begin
            ev              = EV_IRQ;
            cause[XLEN-1]   = 1'b1;
            cause[3:0]      = IRQ_CODE_TIMER;
        end
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Trap entry / mret sequencer: owns the CSR write port while busy, otherwise passes commit writes through.
module csr_trap_ctrl
    import csr_trap_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit VECTORED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_boundary,
    input  logic              exc_valid,
    input  logic [3:0]        exc_cause,
    input  logic [XLEN-1:0]   exc_pc,
    input  logic [XLEN-1:0]   exc_tval,
    input  logic              mret_valid,
    input  logic              ext_irq,
    input  logic              timer_irq,
    input  logic              mstatus_mie,
    input  logic              mie_meie,
    input  logic              mie_mtie,
    input  logic              mstatus_mpie,
    input  logic [XLEN-1:0]   mtvec,
    input  logic [XLEN-1:0]   mepc,
    csr_trap_ctrl_if.slave    wr,
    output logic              busy,
    output logic              flush,
    output logic              redirect_valid,
    output logic [XLEN-1:0]   redirect_pc
);

    state_t          state;
    event_t          sel_ev;
    logic [XLEN-1:0] sel_cause;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] tval_q;
    logic            mie_q;
    logic            ret_q;
    logic            fsm_we;
    logic [11:0]     fsm_addr;
    logic [XLEN-1:0] fsm_data;
    logic [XLEN-1:0] trap_base;
    logic [XLEN-1:0] vec_off;

    csr_trap_prio #(.XLEN(XLEN)) u_prio (
        .exc_valid       (exc_valid),
        .exc_cause       (exc_cause),
        .mret_valid      (mret_valid),
        .commit_boundary (commit_boundary),
        .mstatus_mie     (mstatus_mie),
        .ext_irq         (ext_irq),
        .timer_irq       (timer_irq),
        .mie_meie        (mie_meie),
        .mie_mtie        (mie_mtie),
        .ev              (sel_ev),
        .cause           (sel_cause)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            busy           <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            epc_q          <= '0;
            cause_q        <= '0;
            tval_q         <= '0;
            mie_q          <= 1'b0;
            ret_q          <= 1'b0;
        end else begin
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    case (sel_ev)
                        EV_EXC, EV_IRQ: begin
                            state   <= ST_EPC;
                            busy    <= 1'b1;
                            flush   <= 1'b1;
                            epc_q   <= exc_pc;
                            cause_q <= sel_cause;
                            tval_q  <= (sel_ev == EV_EXC) ? exc_tval : '0;
                            mie_q   <= mstatus_mie;
                            ret_q   <= 1'b0;
                        end
                        EV_MRET: begin
                            state <= ST_MSTAT_RET;
                            busy  <= 1'b1;
                            flush <= 1'b1;
                            ret_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_EPC:   state <= ST_CAUSE;
                ST_CAUSE: state <= ST_TVAL;
                ST_TVAL:  state <= ST_STATUS;
                ST_STATUS, ST_MSTAT_RET: begin
                    state          <= ST_REDIRECT;
                    redirect_valid <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // One sequencer write per busy state; mret reads MPIE live in its write cycle.
    always_comb begin
        fsm_we   = 1'b0;
        fsm_addr = CSR_MSTATUS;
        fsm_data = '0;
        case (state)
            ST_EPC: begin
                fsm_we        = 1'b1;
                fsm_addr      = CSR_MEPC;
                fsm_data      = epc_q;
                fsm_data[1:0] = 2'b00;
            end
            ST_CAUSE: begin
                fsm_we   = 1'b1;
                fsm_addr = CSR_MCAUSE;
                fsm_data = cause_q;
            end
            ST_TVAL: begin
                fsm_we   = 1'b1;
                fsm_addr = CSR_MTVAL;
                fsm_data = tval_q;
            end
            ST_STATUS: begin
                fsm_we                                  = 1'b1;
                fsm_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                fsm_data[MSTATUS_MPIE_BIT]              = mie_q;
            end
            ST_MSTAT_RET: begin
                fsm_we                                  = 1'b1;
                fsm_data[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                fsm_data[MSTATUS_MPIE_BIT]              = 1'b1;
                fsm_data[MSTATUS_MIE_BIT]               = mstatus_mpie;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (state == ST_IDLE) begin
            wr.csr_we           = rst_n & wr.commit_csr_we;
            wr.csr_waddr        = wr.commit_csr_addr;
            wr.csr_wdata        = wr.commit_csr_wdata;
            wr.commit_csr_stall = 1'b0;
        end else begin
            wr.csr_we           = fsm_we;
            wr.csr_waddr        = fsm_addr;
            wr.csr_wdata        = fsm_data;
            wr.commit_csr_stall = wr.commit_csr_we;
        end
    end

    // mtvec/mepc are sampled in REDIRECT itself so a just-committed mtvec write is honoured.
    always_comb begin
        trap_base      = {mtvec[XLEN-1:2], 2'b00};
        vec_off        = '0;
        vec_off[5:2]   = cause_q[3:0];
        redirect_pc    = '0;
        if (state == ST_REDIRECT) begin
            if (ret_q)
                redirect_pc = mepc;
            else if (VECTORED && (mtvec[1:0] == 2'b01) && cause_q[XLEN-1])
                redirect_pc = trap_base + vec_off;
            else
                redirect_pc = trap_base;
        end
    end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Scoreboard bench for csr_trap_ctrl: stimulus pushes expected writes/flushes/redirects, a negedge monitor checks them.
module tb_csr_trap_ctrl;

    typedef struct {
        logic        exc_valid;
        logic [3:0]  exc_cause;
        logic [31:0] exc_pc;
        logic [31:0] exc_tval;
        logic        mret_valid;
        logic        ext_irq;
        logic        timer_irq;
        logic        boundary;
        logic        mie;
        logic        meie;
        logic        mtie;
        logic        mpie;
        logic [31:0] mtvec;
        logic [31:0] mepc;
        logic        cw_en;
        logic [11:0] cw_addr;
        logic [31:0] cw_data;
        int          late_d;
        logic [11:0] late_addr;
        logic [31:0] late_data;
    } stim_t;

    typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int cyc; logic [31:0] pc; } red_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        commit_boundary, exc_valid, mret_valid, ext_irq, timer_irq;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval, mtvec, mepc, redirect_pc;
    logic        mstatus_mie, mie_meie, mie_mtie, mstatus_mpie;
    logic        busy, flush, redirect_valid;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   acc_cyc = -1;
    int   end_cyc = 0;
    wr_t  wq[$];
    int   fq[$];
    red_t rq[$];
    wr_t  mon_w;
    red_t mon_r;
    int   mon_f;
    logic mon_busy;

    csr_trap_ctrl_if #(.XLEN(32)) wr ();

    csr_trap_ctrl #(.XLEN(32), .VECTORED(1'b1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .commit_boundary (commit_boundary),
        .exc_valid       (exc_valid),
        .exc_cause       (exc_cause),
        .exc_pc          (exc_pc),
        .exc_tval        (exc_tval),
        .mret_valid      (mret_valid),
        .ext_irq         (ext_irq),
        .timer_irq       (timer_irq),
        .mstatus_mie     (mstatus_mie),
        .mie_meie        (mie_meie),
        .mie_mtie        (mie_mtie),
        .mstatus_mpie    (mstatus_mpie),
        .mtvec           (mtvec),
        .mepc            (mepc),
        .wr              (wr.slave),
        .busy            (busy),
        .flush           (flush),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportUnexpected(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: output seen with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor: every DUT write, flush and redirect must match the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_busy = (cyc > acc_cyc) && (cyc < end_cyc);
            checkOutput("busy", busy, mon_busy);
            checkOutput("stall", wr.commit_csr_stall, mon_busy & wr.commit_csr_we);
            if (wr.csr_we) begin
                if (wq.size() == 0) reportUnexpected("csr_write");
                else begin
                    mon_w = wq.pop_front();
                    checkOutput("wr_cycle", cyc, mon_w.cyc);
                    checkOutput("wr_addr", wr.csr_waddr, mon_w.addr);
                    checkOutput("wr_data", wr.csr_wdata, mon_w.data);
                end
            end
            if (flush) begin
                if (fq.size() == 0) reportUnexpected("flush");
                else begin
                    mon_f = fq.pop_front();
                    checkOutput("flush_cycle", cyc, mon_f);
                end
            end
            if (redirect_valid) begin
                if (rq.size() == 0) reportUnexpected("redirect");
                else begin
                    mon_r = rq.pop_front();
                    checkOutput("redirect_cycle", cyc, mon_r.cyc);
                    checkOutput("redirect_pc", redirect_pc, mon_r.pc);
                end
            end
        end
    end

    function automatic int modelEvent(input stim_t s);
        if (s.exc_valid) return 1;
        if (s.mret_valid) return 2;
        if (s.boundary && s.mie && s.ext_irq && s.meie) return 3;
        if (s.boundary && s.mie && s.timer_irq && s.mtie) return 4;
        return 0;
    endfunction

    function automatic stim_t blankStim();
        stim_t s;
        s = '{default: '0};
        s.late_d = 0;
        return s;
    endfunction

    function automatic stim_t randStim();
        stim_t s;
        s = blankStim();
        s.exc_valid  = ($urandom_range(0, 3) == 0);
        s.exc_cause  = 4'($urandom);
        s.exc_pc     = $urandom;
        s.exc_tval   = $urandom;
        s.mret_valid = ($urandom_range(0, 3) == 0);
        s.ext_irq    = 1'($urandom);
        s.timer_irq  = 1'($urandom);
        s.boundary   = ($urandom_range(0, 3) != 0);
        s.mie        = 1'($urandom);
        s.meie       = 1'($urandom);
        s.mtie       = 1'($urandom);
        s.mpie       = 1'($urandom);
        s.mtvec      = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
        s.mepc       = $urandom;
        s.cw_en      = ($urandom_range(0, 2) == 0);
        s.cw_addr    = 12'($urandom);
        s.cw_data    = $urandom;
        s.late_d     = $urandom_range(0, 5);
        s.late_addr  = 12'($urandom);
        s.late_data  = $urandom;
        return s;
    endfunction

    task automatic driveEvents(input stim_t s);
        exc_valid       = s.exc_valid;
        exc_cause       = s.exc_cause;
        exc_pc          = s.exc_pc;
        exc_tval        = s.exc_tval;
        mret_valid      = s.mret_valid;
        ext_irq         = s.ext_irq;
        timer_irq       = s.timer_irq;
        commit_boundary = s.boundary;
        mstatus_mie     = s.mie;
        mie_meie        = s.meie;
        mie_mtie        = s.mtie;
        mstatus_mpie    = s.mpie;
        mtvec           = s.mtvec;
        mepc            = s.mepc;
    endtask

    task automatic junkEvents();
        exc_valid       = 1'($urandom);
        exc_cause       = 4'($urandom);
        exc_pc          = $urandom;
        exc_tval        = $urandom;
        mret_valid      = 1'($urandom);
        ext_irq         = 1'($urandom);
        timer_irq       = 1'($urandom);
        commit_boundary = 1'($urandom);
    endtask

    task automatic clearEvents();
        exc_valid       = 1'b0;
        mret_valid      = 1'b0;
        ext_irq         = 1'b0;
        timer_irq       = 1'b0;
        commit_boundary = 1'b0;
    endtask

    // Called just after a rising edge with the DUT idle; returns at the start of the next idle cycle.
    task automatic applyStimulus(input stim_t s);
        int          n, kind, len;
        logic        late;
        logic [31:0] cause, base, rpc;
        n    = cyc;
        kind = modelEvent(s);
        driveEvents(s);
        wr.commit_csr_we    = s.cw_en;
        wr.commit_csr_addr  = s.cw_addr;
        wr.commit_csr_wdata = s.cw_data;
        if (s.cw_en) wq.push_back('{n, s.cw_addr, s.cw_data});
        len = 1;
        if (kind == 1 || kind == 3 || kind == 4) begin
            cause = (kind == 1) ? {28'h0, s.exc_cause} : ((kind == 3) ? 32'h8000_000B : 32'h8000_0007);
            base  = s.mtvec & 32'hFFFF_FFFC;
            rpc   = (kind != 1 && s.mtvec[1:0] == 2'b01) ? base + 32'd4 * (cause % 32'd16) : base;
            wq.push_back('{n + 1, 12'h341, s.exc_pc & 32'hFFFF_FFFC});
            wq.push_back('{n + 2, 12'h342, cause});
            wq.push_back('{n + 3, 12'h343, (kind == 1) ? s.exc_tval : 32'h0});
            wq.push_back('{n + 4, 12'h300, 32'h1800 | (s.mie ? 32'h80 : 32'h0)});
            fq.push_back(n + 1);
            rq.push_back('{n + 5, rpc});
            len = 6;
        end else if (kind == 2) begin
            wq.push_back('{n + 1, 12'h300, 32'h1880 | (s.mpie ? 32'h8 : 32'h0)});
            fq.push_back(n + 1);
            rq.push_back('{n + 2, s.mepc});
            len = 3;
        end
        acc_cyc = n;
        end_cyc = n + len;
        late    = (s.late_d != 0) && (s.late_d < len);
        for (int k = 1; k < len; k++) begin
            @(posedge clk); #1;
            junkEvents();
            wr.commit_csr_we = 1'b0;
            if (late && k >= s.late_d) begin
                wr.commit_csr_we    = 1'b1;
                wr.commit_csr_addr  = s.late_addr;
                wr.commit_csr_wdata = s.late_data;
            end
        end
        @(posedge clk); #1;
        clearEvents();
        wr.commit_csr_we = 1'b0;
        if (late) begin
            wr.commit_csr_we    = 1'b1;
            wr.commit_csr_addr  = s.late_addr;
            wr.commit_csr_wdata = s.late_data;
            wq.push_back('{n + len, s.late_addr, s.late_data});
            @(posedge clk); #1;
            wr.commit_csr_we = 1'b0;
        end
    endtask

    // Exception whose sequence is cut by reset during TVAL: only EPC and CAUSE writes may appear.
    task automatic applyResetMidTrap(input stim_t s);
        int n;
        n = cyc;
        driveEvents(s);
        wq.push_back('{n + 1, 12'h341, s.exc_pc & 32'hFFFF_FFFC});
        wq.push_back('{n + 2, 12'h342, {28'h0, s.exc_cause}});
        fq.push_back(n + 1);
        acc_cyc = n;
        end_cyc = n + 3;
        @(posedge clk); #1;
        clearEvents();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n            = 1'b0;
        wr.commit_csr_we = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_flush", flush, 1'b0);
        checkOutput("midrst_redirect_valid", redirect_valid, 1'b0);
        checkOutput("midrst_redirect_pc", redirect_pc, 32'h0);
        checkOutput("midrst_csr_we", wr.csr_we, 1'b0);
        checkOutput("midrst_stall", wr.commit_csr_stall, 1'b0);
        @(posedge clk); #1;
        wr.commit_csr_we = 1'b0;
        rst_n            = 1'b1;
    endtask

    initial begin
        stim_t s;
        rst_n = 1'b0;
        clearEvents();
        exc_cause = '0; exc_pc = '0; exc_tval = '0;
        mstatus_mie = 1'b0; mie_meie = 1'b0; mie_mtie = 1'b0; mstatus_mpie = 1'b0;
        mtvec = '0; mepc = '0;
        wr.commit_csr_we    = 1'b1;
        wr.commit_csr_addr  = 12'h305;
        wr.commit_csr_wdata = 32'h1234;
        #12;
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_flush", flush, 1'b0);
        checkOutput("rst_redirect_valid", redirect_valid, 1'b0);
        checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
        checkOutput("rst_csr_we", wr.csr_we, 1'b0);
        wr.commit_csr_we = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        s = blankStim();
        s.exc_valid = 1'b1; s.exc_cause = 4'd2; s.exc_pc = 32'h100; s.exc_tval = 32'hDEAD;
        s.mtvec = 32'h80; s.mie = 1'b1;
        applyStimulus(s);

        s = blankStim();
        s.timer_irq = 1'b1; s.mtie = 1'b1; s.mie = 1'b1; s.boundary = 1'b1;
        s.mtvec = 32'h81; s.exc_pc = 32'h400;
        applyStimulus(s);

        s = blankStim();
        s.ext_irq = 1'b1; s.meie = 1'b1; s.mie = 1'b0; s.boundary = 1'b1;
        applyStimulus(s);
        s.mie = 1'b1; s.boundary = 1'b0;
        applyStimulus(s);

        s = blankStim();
        s.mret_valid = 1'b1; s.mpie = 1'b1; s.mepc = 32'h200;
        applyStimulus(s);

        s = blankStim();
        s.exc_valid = 1'b1; s.exc_cause = 4'd5; s.exc_pc = 32'h2002; s.exc_tval = 32'h77;
        s.mtvec = 32'h1000; s.mie = 1'b0;
        s.late_d = 2; s.late_addr = 12'h305; s.late_data = 32'h0000_3001;
        applyStimulus(s);

        s = blankStim();
        s.exc_valid = 1'b1; s.exc_cause = 4'd11; s.exc_pc = 32'h500; s.exc_tval = 32'h9;
        s.mret_valid = 1'b1; s.ext_irq = 1'b1; s.meie = 1'b1; s.mie = 1'b1; s.boundary = 1'b1;
        s.mtvec = 32'h301;
        applyStimulus(s);

        s = blankStim();
        s.ext_irq = 1'b1; s.meie = 1'b1; s.timer_irq = 1'b1; s.mtie = 1'b1;
        s.mie = 1'b1; s.boundary = 1'b1; s.mtvec = 32'h4001; s.exc_pc = 32'h604;
        s.cw_en = 1'b1; s.cw_addr = 12'h304; s.cw_data = 32'h880;
        applyStimulus(s);

        for (int i = 0; i < 60; i++) applyStimulus(randStim());

        s = blankStim();
        s.exc_valid = 1'b1; s.exc_cause = 4'd3; s.exc_pc = 32'h700; s.exc_tval = 32'h1;
        s.mtvec = 32'h80; s.mie = 1'b1;
        applyResetMidTrap(s);

        s.exc_cause = 4'd4; s.exc_pc = 32'h804;
        applyStimulus(s);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("writes_left", wq.size(), 0);
        checkOutput("flushes_left", fq.size(), 0);
        checkOutput("redirects_left", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
